md_hilo_ctrl: RTL and testbench
===============================

# md_hilo_ctrl

Multiply/divide-unit controller between the execute stage and the iterative `divider`. It accepts DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from execute and launches the divider with registered operands. It stalls the pipeline while a result is pending, captures quotient/remainder into the architectural LO/HI registers, and serves MFHI/MFLO reads.

## Interface
- `DATA_WIDTH`, default 32: operand and HI/LO width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: execute-stage op valid this cycle.
- `ex_op` in 3: op code, one of 000 NONE, 001 DIV, 010 DIVU, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO.
- `ex_rs` in DATA_WIDTH: dividend, or MT source.
- `ex_rt` in DATA_WIDTH: divisor.
- `ex_flush` in 1: kill the in-flight op and any pending divide result.
- `stall` out 1: combinational; hold the execute stage.
- `mf_data` out DATA_WIDTH: combinational; HI for MFHI, LO for MFLO, 0 otherwise.
- `hi` out DATA_WIDTH: architectural HI.
- `lo` out DATA_WIDTH: architectural LO.
- `div_req` out 1: registered divider enable, one-cycle pulse.
- `div_signed` out 1: registered; 1 for DIV, 0 for DIVU.
- `div_dividend` out DATA_WIDTH: registered divider dividend.
- `div_divisor` out DATA_WIDTH: registered divider divisor.
- `div_quotient` in DATA_WIDTH: divider quotient; valid only while `div_complete`=1.
- `div_remainder` in DATA_WIDTH: divider remainder; valid only while `div_complete`=1.
- `div_complete` in 1: divider one-cycle done strobe.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, DRAIN.
- **Divide op (IDLE).** Condition: `ex_valid`, op DIV or DIVU, `!ex_flush`.
  - Latch `ex_rs` into `div_dividend` and `ex_rt` into `div_divisor`.
  - Set `div_signed` from the op.
  - Go to LAUNCH.
- **LAUNCH.** `div_req`=1 for exactly this cycle, then go to WAIT. Operands are held stable until `div_complete`.
- **WAIT.** On `div_complete`: LO ← `div_quotient`, HI ← `div_remainder`, go to IDLE.
- **MTHI/MTLO (IDLE, not flushed).** HI or LO ← `ex_rs` at the next edge; no stall.
- **MFHI/MFLO.** `mf_data` shows the current register value. A write at edge T is visible at cycle T+1; there is no same-cycle bypass.
- **Stall rule.** `stall` = !rst & (
  - state ∈ {LAUNCH, WAIT}, or
  - (state==IDLE & `ex_valid` & op∈{DIV,DIVU} & !`ex_flush`), or
  - (state==DRAIN & `ex_valid` & op∈{DIV,DIVU,MTHI,MTLO}) ).
- **DRAIN.** MFHI/MFLO pass without stall, since HI/LO will not change.
- **Flush in LAUNCH or WAIT.** The divider cannot abort.
  - Go to DRAIN; if `ex_flush` coincides with `div_complete` in WAIT, discard the result and go straight to IDLE.
  - If flush happens in LAUNCH, still issue the `div_req` pulse, then enter DRAIN.
  - In DRAIN, wait for `div_complete`, discard the result (HI/LO unchanged), then go to IDLE.
- **Flush in IDLE** in the same cycle as an op: the op is ignored.
- **Divide by zero:** no trap. HI/LO take whatever the divider returns.
- **Width:** all paths are DATA_WIDTH, with no extension or truncation.

## Timing
- Reset values: state IDLE; `hi`, `lo`, `div_dividend`, `div_divisor` = 0; `div_req`, `div_signed` = 0; `stall`=0 while `rst`=1.
- Divider contract: `div_complete` arrives 33 cycles after the `div_req` cycle.
- Divide latency, with DIV accepted in cycle T:
  - `div_req` is high in T+1.
  - `div_complete` is high in T+34.
  - HI/LO are updated at the T+34 edge.
  - State is IDLE in T+35.
- `stall` is high in cycles T..T+34 (35 cycles) and low in T+35. The next op is accepted in T+35.
- `div_complete` seen in IDLE or LAUNCH is a protocol error and is ignored.
- Reset mid-operation: the divider shares `rst`, so both return to idle. Any partial result is lost.

## Structure
- Shared package `md_pkg`: op-code localparams (MD_NONE…MD_MFLO), FSM state encoding, DATA_WIDTH default.
- Optional sub-module `hilo_reg`: HI/LO pair with two write ports (divide capture, MT). Capture and MT never coincide because MT is blocked outside IDLE.
- The divider is instantiated beside this block at execute-stage top level and is not nested inside it.

## Test plan
- DIV with rs=0xFFFFFFF9 (-7), rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; `stall` high for exactly 35 cycles.
- DIVU with rs=0xFFFFFFFF, rt=16 → LO=0x0FFFFFFF, HI=0x0000000F; `div_signed`=0 during `div_req`.
- MTHI 0x12345678 at T, MFHI at T+1 → `mf_data`=0x12345678 at T+1, no stall; MFLO still returns the old LO.
- DIV 100/7, flush at T+10 → DRAIN.
  - MFLO at T+12 does not stall.
  - DIVU at T+12 stalls until the complete cycle +1.
  - HI/LO remain at old values; the subsequent DIVU result lands correctly.
- Back-to-back DIV 20/3 then DIVU 9/4 → LO=6/HI=2, then LO=2/HI=1; second `div_req` exactly at T+36.
- `rst` asserted at T+20 of a divide → next cycle: state IDLE, hi=lo=0, stall=0; a fresh DIV then completes in 35 cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared op codes, FSM state encoding and op decode for the HI/LO multiply/divide controller.
package md_pkg;

  localparam int MD_DATA_WIDTH = 32;

  localparam logic [2:0] MD_NONE = 3'b000;
  localparam logic [2:0] MD_DIV  = 3'b001;
  localparam logic [2:0] MD_DIVU = 3'b010;
  localparam logic [2:0] MD_MTHI = 3'b011;
  localparam logic [2:0] MD_MTLO = 3'b100;
  localparam logic [2:0] MD_MFHI = 3'b101;
  localparam logic [2:0] MD_MFLO = 3'b110;

  localparam logic [1:0] MD_ST_IDLE   = 2'b00;
  localparam logic [1:0] MD_ST_LAUNCH = 2'b01;
  localparam logic [1:0] MD_ST_WAIT   = 2'b10;
  localparam logic [1:0] MD_ST_DRAIN  = 2'b11;

  typedef struct packed {
    logic div;
    logic sgn;
    logic mthi;
    logic mtlo;
    logic mfhi;
    logic mflo;
  } md_dec_t;

  function automatic md_dec_t md_decode(input logic [2:0] op);
    md_dec_t d;
    d      = '0;
    d.div  = (op == MD_DIV) || (op == MD_DIVU);
    d.sgn  = (op == MD_DIV);
    d.mthi = (op == MD_MTHI);
    d.mtlo = (op == MD_MTLO);
    d.mfhi = (op == MD_MFHI);
    d.mflo = (op == MD_MFLO);
    return d;
  endfunction

endpackage

// File: rtl/md_hilo_ctrl_hilo_reg.sv
// Architectural HI/LO pair: divide-capture port has priority over the MT port; writes
// land at the next edge, no backpressure (the controller never presents both at once).
module hilo_reg
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_en,
  input  logic [DATA_WIDTH-1:0] cap_hi,
  input  logic [DATA_WIDTH-1:0] cap_lo,
  input  logic                  mthi_en,
  input  logic                  mtlo_en,
  input  logic [DATA_WIDTH-1:0] mt_data,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (cap_en) begin
      hi_d = cap_hi;
      lo_d = cap_lo;
    end else begin
      if (mthi_en) hi_d = mt_data;
      if (mtlo_en) lo_d = mt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/md_hilo_ctrl.sv
// Mul/div controller: launches the external divider one cycle after accept, result in HI/LO
// 34 cycles after accept; stalls execute while a divide is pending or a new one is accepted.
module md_hilo_ctrl
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [2:0]            ex_op,
  input  logic [DATA_WIDTH-1:0] ex_rs,
  input  logic [DATA_WIDTH-1:0] ex_rt,
  input  logic                  ex_flush,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] mf_data,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_req,
  output logic                  div_signed,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  input  logic                  div_complete
);

  md_dec_t dec;

  logic [1:0]            state_q, state_d;
  logic                  div_req_q, div_req_d;
  logic                  signed_q, signed_d;
  logic [DATA_WIDTH-1:0] dividend_q, dividend_d;
  logic [DATA_WIDTH-1:0] divisor_q, divisor_d;

  logic accept_div;
  logic cap_en;
  logic mthi_en;
  logic mtlo_en;
  logic in_idle;
  logic drain_block;

  assign dec     = md_decode(ex_op);
  assign in_idle = (state_q == MD_ST_IDLE);

  assign accept_div = in_idle && ex_valid && dec.div && !ex_flush;
  assign mthi_en    = in_idle && ex_valid && dec.mthi && !ex_flush;
  assign mtlo_en    = in_idle && ex_valid && dec.mtlo && !ex_flush;

  // While draining a killed divide HI/LO are stable, so only ops that would write them wait.
  assign drain_block = (state_q == MD_ST_DRAIN) && ex_valid && (dec.div || dec.mthi || dec.mtlo);

  assign stall = !rst && ((state_q == MD_ST_LAUNCH) || (state_q == MD_ST_WAIT) ||
                          accept_div || drain_block);

  always_comb begin
    state_d    = state_q;
    signed_d   = signed_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    div_req_d  = accept_div;
    cap_en     = 1'b0;
    case (state_q)
      MD_ST_IDLE: begin
        if (accept_div) begin
          state_d    = MD_ST_LAUNCH;
          signed_d   = dec.sgn;
          dividend_d = ex_rs;
          divisor_d  = ex_rt;
        end
      end
      MD_ST_LAUNCH: begin
        // div_req is already out this cycle; the divider cannot abort, so a flush drains it.
        state_d = ex_flush ? MD_ST_DRAIN : MD_ST_WAIT;
      end
      MD_ST_WAIT: begin
        if (div_complete) begin
          state_d = MD_ST_IDLE;
          cap_en  = !ex_flush;
        end else if (ex_flush) begin
          state_d = MD_ST_DRAIN;
        end
      end
      MD_ST_DRAIN: begin
        if (div_complete) state_d = MD_ST_IDLE;
      end
      default: state_d = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_ST_IDLE;
      div_req_q  <= 1'b0;
      signed_q   <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_req_q  <= div_req_d;
      signed_q   <= signed_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
    end
  end

  hilo_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hilo (
    .clk    (clk),
    .rst    (rst),
    .cap_en (cap_en),
    .cap_hi (div_remainder),
    .cap_lo (div_quotient),
    .mthi_en(mthi_en),
    .mtlo_en(mtlo_en),
    .mt_data(ex_rs),
    .hi     (hi),
    .lo     (lo)
  );

  always_comb begin
    mf_data = '0;
    if (dec.mfhi)      mf_data = hi;
    else if (dec.mflo) mf_data = lo;
  end

  assign div_req      = div_req_q;
  assign div_signed   = signed_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed bench for md_hilo_ctrl with a 33-cycle behavioural divider alongside.
module tb_md_hilo_ctrl;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b001;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b011;
  localparam logic [2:0] OP_MTLO = 3'b100;
  localparam logic [2:0] OP_MFHI = 3'b101;
  localparam logic [2:0] OP_MFLO = 3'b110;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_flush;
  logic        stall;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_complete;

  logic        mdl_cmp;
  logic        inj;
  logic [31:0] mdl_q, mdl_r, mdl_a, mdl_b;
  logic        mdl_s;
  int          mdl_cnt;

  int total = 0;
  int bad   = 0;

  md_hilo_ctrl #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_flush     (ex_flush),
    .stall        (stall),
    .mf_data      (mf_data),
    .hi           (hi),
    .lo           (lo),
    .div_req      (div_req),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_complete (div_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Injected strobe carries garbage data so an accepted protocol-error strobe shows in HI/LO.
  assign div_complete  = mdl_cmp | inj;
  assign div_quotient  = inj ? 32'h1111_1111 : mdl_q;
  assign div_remainder = inj ? 32'h2222_2222 : mdl_r;

  // Divider: complete strobe 33 cycles after the div_req cycle, shares rst.
  initial begin
    mdl_cmp = 1'b0; mdl_q = '0; mdl_r = '0; mdl_a = '0; mdl_b = '0; mdl_s = 1'b0; mdl_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mdl_cmp = 1'b0;
      if (rst) begin
        mdl_cnt = 0;
      end else begin
        if (mdl_cnt > 0) begin
          mdl_cnt--;
          if (mdl_cnt == 0) begin
            mdl_cmp = 1'b1;
            if (mdl_b == 0) begin
              mdl_q = '1;
              mdl_r = mdl_a;
            end else if (mdl_s) begin
              mdl_q = $signed(mdl_a) / $signed(mdl_b);
              mdl_r = $signed(mdl_a) % $signed(mdl_b);
            end else begin
              mdl_q = mdl_a / mdl_b;
              mdl_r = mdl_a % mdl_b;
            end
          end
        end
        if (div_req) begin
          mdl_cnt = 33;
          mdl_a   = div_dividend;
          mdl_b   = div_divisor;
          mdl_s   = div_signed;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    @(negedge clk);
    ex_valid = v; ex_op = op; ex_rs = rs; ex_rt = rt; ex_flush = fl;
    #2;
  endtask

  // Full divide from accept (cycle T) to T+35; pre=1 means the op was already driven at T.
  task automatic do_div(input string tag, input logic pre, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic [31:0] old_lo, input logic [31:0] old_hi,
                        input logic exp_sgn, input logic [2:0] nop,
                        input logic [31:0] nrs, input logic [31:0] nrt);
    int nst;
    if (!pre) apply(1'b1, op, rs, rt, 1'b0);
    chk({tag, "_accept_stall"}, 32'(stall), 32'd1);
    nst = int'(stall);
    for (int k = 1; k <= 34; k++) begin
      apply(1'b0, OP_NONE, '0, '0, 1'b0);
      nst += int'(stall);
      if (k == 1) begin
        chk({tag, "_req"}, 32'(div_req), 32'd1);
        chk({tag, "_signed"}, 32'(div_signed), 32'(exp_sgn));
        chk({tag, "_dividend"}, div_dividend, rs);
        chk({tag, "_divisor"}, div_divisor, rt);
      end
      if (k == 2) chk({tag, "_req_pulse"}, 32'(div_req), 32'd0);
      if (k == 34) begin
        chk({tag, "_hi_before"}, hi, old_hi);
        chk({tag, "_lo_before"}, lo, old_lo);
      end
    end
    apply(nop != OP_NONE, nop, nrs, nrt, 1'b0);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_stall_cycles"}, 32'(nst), 32'd35);
    chk({tag, "_next_stall"}, 32'(stall), 32'((nop == OP_DIV) || (nop == OP_DIVU)));
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [31:0] rs;
    logic        fl;
    logic        e_stall;
    logic [31:0] e_mf;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_req;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, OP_MTHI, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0};
    tbl[1]  = '{1'b1, OP_MFHI, 32'h0,         1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'h0,         1'b0};
    tbl[2]  = '{1'b1, OP_MFLO, 32'h0,         1'b0, 1'b0, 32'h0,         32'h1234_5678, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, OP_MTLO, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,         32'h1234_5678, 32'h0,         1'b0};
    tbl[4]  = '{1'b1, OP_MFLO, 32'h0,         1'b0, 1'b0, 32'h0,         32'h1234_5678, 32'h0,         1'b0};
    tbl[5]  = '{1'b0, OP_MTLO, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         32'h1234_5678, 32'h0,         1'b0};
    tbl[6]  = '{1'b1, OP_MTLO, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0,         32'h1234_5678, 32'h0,         1'b0};
    tbl[7]  = '{1'b1, OP_MFLO, 32'h0,         1'b0, 1'b0, 32'hA5A5_5A5A, 32'h1234_5678, 32'hA5A5_5A5A, 1'b0};
    tbl[8]  = '{1'b1, OP_DIV,  32'h0000_0064, 1'b1, 1'b0, 32'h0,         32'h1234_5678, 32'hA5A5_5A5A, 1'b0};
    tbl[9]  = '{1'b1, OP_NONE, 32'h0,         1'b0, 1'b0, 32'h0,         32'h1234_5678, 32'hA5A5_5A5A, 1'b0};
    tbl[10] = '{1'b0, OP_DIV,  32'h0000_0064, 1'b0, 1'b0, 32'h0,         32'h1234_5678, 32'hA5A5_5A5A, 1'b0};
    tbl[11] = '{1'b1, OP_MFHI, 32'h0,         1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, 32'hA5A5_5A5A, 1'b0};

    rst = 1'b1; inj = 1'b0;
    ex_valid = 1'b1; ex_op = OP_DIV; ex_rs = 32'd5; ex_rt = 32'd1; ex_flush = 1'b0;

    // Reset: a valid DIV must not stall while rst is high.
    @(negedge clk); #2;
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0; ex_op = OP_NONE; ex_rs = '0; ex_rt = '0;
    #2;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_req", 32'(div_req), 32'd0);
    chk("rst_signed", 32'(div_signed), 32'd0);
    chk("rst_dividend", div_dividend, 32'h0);
    chk("rst_divisor", div_divisor, 32'h0);
    chk("rst_idle_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].v, tbl[i].op, tbl[i].rs, 32'd7, tbl[i].fl);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d_mf", i), mf_data, tbl[i].e_mf);
      chk($sformatf("vec%0d_hi", i), hi, tbl[i].e_hi);
      chk($sformatf("vec%0d_lo", i), lo, tbl[i].e_lo);
      chk($sformatf("vec%0d_req", i), 32'(div_req), 32'(tbl[i].e_req));
    end

    // Signed -7/2, then unsigned 0xFFFFFFFF/16.
    do_div("div_neg", 1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
           32'hA5A5_5A5A, 32'h1234_5678, 1'b1, OP_NONE, '0, '0);
    do_div("divu_big", 1'b0, OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'h0000_000F,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, OP_NONE, '0, '0);

    // Back-to-back: DIVU accepted at T+35 of the first divide.
    do_div("b2b_a", 1'b0, OP_DIV, 32'd20, 32'd3, 32'd6, 32'd2,
           32'h0FFF_FFFF, 32'h0000_000F, 1'b1, OP_DIVU, 32'd9, 32'd4);
    do_div("b2b_b", 1'b1, OP_DIVU, 32'd9, 32'd4, 32'd2, 32'd1,
           32'd6, 32'd2, 1'b0, OP_NONE, '0, '0);

    // Flush in WAIT at T+10, then DRAIN behaviour.
    begin
      int nst;
      apply(1'b1, OP_DIV, 32'd100, 32'd7, 1'b0);
      for (int k = 1; k <= 9; k++) apply(1'b0, OP_NONE, '0, '0, 1'b0);
      apply(1'b0, OP_NONE, '0, '0, 1'b1);
      chk("fl_wait_stall", 32'(stall), 32'd1);
      apply(1'b0, OP_NONE, '0, '0, 1'b0);
      chk("fl_drain_nop_stall", 32'(stall), 32'd0);
      apply(1'b1, OP_MFLO, '0, '0, 1'b0);
      chk("fl_drain_mflo_stall", 32'(stall), 32'd0);
      chk("fl_drain_mflo_data", mf_data, 32'd2);
      apply(1'b1, OP_MTHI, 32'hDEAD_0001, '0, 1'b0);
      chk("fl_drain_mthi_stall", 32'(stall), 32'd1);
      nst = 0;
      for (int k = 14; k <= 34; k++) begin
        apply(1'b1, OP_DIVU, 32'd1000, 32'd9, 1'b0);
        nst += int'(stall);
      end
      chk("fl_drain_divu_stalls", 32'(nst), 32'd21);
      apply(1'b1, OP_DIVU, 32'd1000, 32'd9, 1'b0);
      chk("fl_accept_stall", 32'(stall), 32'd1);
      chk("fl_discard_hi", hi, 32'd1);
      chk("fl_discard_lo", lo, 32'd2);
      apply(1'b0, OP_NONE, '0, '0, 1'b0);
      chk("fl_req", 32'(div_req), 32'd1);
      chk("fl_req_signed", 32'(div_signed), 32'd0);
      chk("fl_req_dividend", div_dividend, 32'd1000);
      for (int k = 37; k <= 69; k++) apply(1'b0, OP_NONE, '0, '0, 1'b0);
      chk("fl_lo_before", lo, 32'd2);
      apply(1'b0, OP_NONE, '0, '0, 1'b0);
      chk("fl_divu_lo", lo, 32'h6F);
      chk("fl_divu_hi", hi, 32'd1);
    end

    // Flush in LAUNCH: the pulse still goes out, then DRAIN until the complete strobe.
    apply(1'b1, OP_DIV, 32'd50, 32'd5, 1'b0);
    apply(1'b0, OP_NONE, '0, '0, 1'b1);
    chk("fl_launch_req", 32'(div_req), 32'd1);
    apply(1'b0, OP_NONE, '0, '0, 1'b0);
    chk("fl_launch_drain_stall", 32'(stall), 32'd0);
    for (int k = 3; k <= 33; k++) apply(1'b0, OP_NONE, '0, '0, 1'b0);
    apply(1'b1, OP_MTLO, 32'd77, '0, 1'b0);
    chk("fl_launch_mtlo_stall_drain", 32'(stall), 32'd1);
    apply(1'b1, OP_MTLO, 32'd77, '0, 1'b0);
    chk("fl_launch_mtlo_stall_idle", 32'(stall), 32'd0);
    apply(1'b0, OP_NONE, '0, '0, 1'b0);
    chk("fl_launch_lo", lo, 32'd77);
    chk("fl_launch_hi", hi, 32'd1);

    // Flush coinciding with complete: straight to IDLE, result discarded.
    apply(1'b1, OP_DIV, 32'd50, 32'd5, 1'b0);
    for (int k = 1; k <= 33; k++) apply(1'b0, OP_NONE, '0, '0, 1'b0);
    apply(1'b0, OP_NONE, '0, '0, 1'b1);
    apply(1'b1, OP_MTHI, 32'd88, '0, 1'b0);
    chk("fl_cmp_idle_stall", 32'(stall), 32'd0);
    chk("fl_cmp_hi", hi, 32'd1);
    chk("fl_cmp_lo", lo, 32'd77);
    apply(1'b0, OP_NONE, '0, '0, 1'b0);
    chk("fl_cmp_mthi", hi, 32'd88);

    // Stray complete strobe in IDLE is ignored.
    @(negedge clk);
    ex_valid = 1'b0; ex_op = OP_NONE; inj = 1'b1;
    #2;
    apply(1'b0, OP_NONE, '0, '0, 1'b0);
    inj = 1'b0;
    chk("stray_cmp_hi", hi, 32'd88);
    chk("stray_cmp_lo", lo, 32'd77);
    chk("stray_cmp_stall", 32'(stall), 32'd0);

    // Reset at T+20 of a divide, then a fresh divide.
    apply(1'b1, OP_DIV, 32'd64, 32'd8, 1'b0);
    for (int k = 1; k <= 19; k++) apply(1'b0, OP_NONE, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("midrst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_after_stall", 32'(stall), 32'd0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_req", 32'(div_req), 32'd0);
    do_div("post_rst", 1'b0, OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE,
           32'h0, 32'h0, 1'b1, OP_NONE, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
